// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter with round-robin tie breaking and a
// per-transfer ack timeout. Arbitration is registered; the granted master's
// request is then passed straight through to the shared slave.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   m0_* / m1_*            master request inputs (adr, dat, we, sel, stb, cyc)
//                          and response outputs (dat, ack, err)
//   s_*                    shared slave request outputs and response inputs
//   grant_o                one-hot owner: bit0 = m0, bit1 = m1, 00 = idle
module wb_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Counter value on which an unacked strobe is aborted.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        last;
    logic [7:0]  cnt;
    logic [1:0]  grant_q;

    logic        sel0;
    logic        sel1;
    logic        busy;

    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        req_we;
    logic [3:0]  req_sel;
    logic        req_stb;
    logic        req_cyc;

    logic        timeout_hit;
    logic        abort;
    logic        ack_gate;
    logic        err_gate;

    assign sel0 = (state == BUSY0);
    assign sel1 = (state == BUSY1);
    assign busy = sel0 | sel1;

    // Request of the current owner; all zero while idle.
    always_comb begin
        req_adr = '0;
        req_dat = '0;
        req_we  = 1'b0;
        req_sel = '0;
        req_stb = 1'b0;
        req_cyc = 1'b0;
        unique case (1'b1)
            sel0: begin
                req_adr = m0_adr_i;
                req_dat = m0_dat_i;
                req_we  = m0_we_i;
                req_sel = m0_sel_i;
                req_stb = m0_stb_i;
                req_cyc = m0_cyc_i;
            end
            sel1: begin
                req_adr = m1_adr_i;
                req_dat = m1_dat_i;
                req_we  = m1_we_i;
                req_sel = m1_sel_i;
                req_stb = m1_stb_i;
                req_cyc = m1_cyc_i;
            end
            default: ;
        endcase
    end

    // A same-cycle ack always beats the timeout.
    assign timeout_hit = busy & req_stb & ~s_ack_i & (cnt == TO_LAST);

    // Reset kills the bus cycle and every response in the same cycle.
    assign abort    = timeout_hit | rst;
    assign ack_gate = s_ack_i & ~rst;
    assign err_gate = timeout_hit & ~rst;

    assign s_adr_o = req_adr;
    assign s_dat_o = req_dat;
    assign s_we_o  = req_we;
    assign s_sel_o = req_sel;
    assign s_stb_o = req_stb & ~abort;
    assign s_cyc_o = req_cyc & ~abort;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = sel0 & ack_gate;
    assign m1_ack_o = sel1 & ack_gate;
    assign m0_err_o = sel0 & err_gate;
    assign m1_err_o = sel1 & err_gate;

    assign grant_o = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            grant_q <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    // m0 wins when alone, or on a tie after m1 was served.
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state   <= BUSY0;
                        last    <= 1'b0;
                        grant_q <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state   <= BUSY1;
                        last    <= 1'b1;
                        grant_q <= 2'b10;
                    end
                end
                BUSY0, BUSY1: begin
                    if (timeout_hit || !req_cyc) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        cnt     <= '0;
                    end else if (req_stb && !s_ack_i) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2 (TIMEOUT = 4).
// Responses are predicted into a scoreboard and matched by a monitor.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic        m0_we_i, m0_stb_i, m0_cyc_i;
    logic        m1_we_i, m1_stb_i, m1_cyc_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;

    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        bit          is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_stb_i (m0_stb_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_stb_i (m1_stb_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o)
    );

    // Response monitor: every ack/err must match the oldest prediction.
    always @(negedge clk) begin
        logic [1:0]  ackv;
        logic [1:0]  errv;
        logic [31:0] datv [2];
        exp_t        e;
        ackv    = {m1_ack_o, m0_ack_o};
        errv    = {m1_err_o, m0_err_o};
        datv[0] = m0_dat_o;
        datv[1] = m1_dat_o;
        for (int m = 0; m < 2; m++) begin
            if (ackv[m] || errv[m]) begin
                checks++;
                if (ackv[m] && errv[m]) begin
                    errors++;
                    $display("FAIL resp_m%0d: ack and err both high", m);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_m%0d: got ack=%0b err=%0b, want none",
                             m, ackv[m], errv[m]);
                end else begin
                    e = sb.pop_front();
                    if (e.m != m || e.is_err != errv[m] ||
                        (!e.is_err && datv[m] !== e.dat)) begin
                        errors++;
                        $display("FAIL resp_m%0d: got err=%0b dat=%h, want m%0d err=%0b dat=%h",
                                 m, errv[m], datv[m], e.m, e.is_err, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb,
                         input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
        end
    endtask

    task automatic expect_resp(input int m, input bit is_err,
                               input logic [31:0] dat);
        exp_t e;
        e.m = m;
        e.is_err = is_err;
        e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
        s_ack_i = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        drive(0, 1, 1, 1, 32'h10, 32'h20, 4'hF);
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m0_ack_o !== 1'b0 ||
            m0_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: cyc=%b stb=%b ack0=%b err0=%b ack1=%b, want 0",
                     s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o);
        end
        tick();
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_adr_o !== 32'h0 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b adr=%h cyc=%b, want 00/0/0",
                     grant_o, s_adr_o, s_cyc_o);
        end
        idle_all();
        rst = 1'b0;
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: grant=%b stb=%b, want 00/0", grant_o, s_stb_o);
        end
    endtask

    task automatic test_ack_in_idle();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD0000;
        #1;
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: ack0=%b ack1=%b cyc=%b, want 0",
                     m0_ack_o, m1_ack_o, s_cyc_o);
        end
        tick();
        s_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        drive(0, 1, 1, 1, 32'h100, 32'hCAFE0001, 4'hF);
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pre: grant=%b cyc=%b, want 00/0", grant_o, s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 ||
            s_adr_o !== 32'h100 || s_dat_o !== 32'hCAFE0001 ||
            s_we_o !== 1'b1 || s_sel_o !== 4'hF || m0_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_fwd: grant=%b cyc=%b adr=%h dat=%h we=%b sel=%h ack=%b",
                     grant_o, s_cyc_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, m0_ack_o);
        end
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h5A5A0000;
        expect_resp(0, 1'b0, 32'h5A5A0000);
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack0=%b ack1=%b, want 1/0", m0_ack_o, m1_ack_o);
        end
        tick();
        idle_all();
        #1;
        checks++;
        if (m0_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_len: ack0=%b, want 0", m0_ack_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL single_release: grant=%b, want 00", grant_o);
        end
    endtask

    task automatic test_tie();
        logic [1:0] want;
        pulse_reset();
        drive(0, 1, 1, 0, 32'h200, '0, 4'hF);
        drive(1, 1, 1, 0, 32'h300, '0, 4'hF);
        tick();
        checks++;
        if (grant_o !== 2'b01 || s_adr_o !== 32'h200) begin
            errors++;
            $display("FAIL tie_first: grant=%b adr=%h, want 01/200", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'h000000A0;
        expect_resp(0, 1'b0, 32'h000000A0);
        tick();
        s_ack_i = 1'b0;
        drive(0, 0, 0, 0, '0, '0, '0);
        tick();
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_gap: grant=%b cyc=%b, want 00/0", grant_o, s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_adr_o !== 32'h300) begin
            errors++;
            $display("FAIL tie_second: grant=%b adr=%h, want 10/300", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'h000000A1;
        expect_resp(1, 1'b0, 32'h000000A1);
        tick();
        idle_all();
        tick();
        tick();
        for (int r = 0; r < 4; r++) begin
            drive(0, 1, 1, 0, 32'h200 + r, '0, 4'hF);
            drive(1, 1, 1, 0, 32'h300 + r, '0, 4'hF);
            tick();
            want = (r % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (grant_o !== want) begin
                errors++;
                $display("FAIL tie_round%0d: grant=%b, want %b", r, grant_o, want);
            end
            s_ack_i = 1'b1;
            s_dat_i = 32'hB0 + r;
            expect_resp(r % 2, 1'b0, 32'hB0 + r);
            tick();
            idle_all();
            tick();
            tick();
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        drive(1, 1, 1, 0, 32'h400, '0, 4'hF);
        tick();
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (s_stb_o !== 1'b1 || m1_err_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: stb=%b err=%b, want 1/0", k, s_stb_o, m1_err_o);
            end
            tick();
        end
        expect_resp(1, 1'b1, '0);
        #1;
        checks++;
        if (m1_err_o !== 1'b1 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0 ||
            s_stb_o !== 1'b0 || grant_o !== 2'b10) begin
            errors++;
            $display("FAIL timeout_fire: err=%b ack=%b cyc=%b stb=%b grant=%b",
                     m1_err_o, m1_ack_o, s_cyc_o, s_stb_o, grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: grant=%b err=%b cyc=%b, want 00/0/0",
                     grant_o, m1_err_o, s_cyc_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rearb: grant=%b cyc=%b, want 10/1", grant_o, s_cyc_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'h0000C001;
        expect_resp(1, 1'b0, 32'h0000C001);
        tick();
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_collision();
        pulse_reset();
        drive(1, 1, 1, 0, 32'h440, '0, 4'hF);
        tick();
        tick();
        tick();
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h00000077;
        expect_resp(1, 1'b0, 32'h00000077);
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL collision: ack=%b err=%b cyc=%b, want 1/0/1",
                     m1_ack_o, m1_err_o, s_cyc_o);
        end
        tick();
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_burst();
        int waits [3] = '{2, 2, 0};
        drive(0, 1, 1, 1, 32'h500, 32'h1, 4'hF);
        tick();
        drive(1, 1, 1, 0, 32'h900, '0, 4'hF);
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < waits[s]; w++) begin
                checks++;
                if (grant_o !== 2'b01 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_wait%0d: grant=%b ack1=%b err0=%b",
                             s, grant_o, m1_ack_o, m0_err_o);
                end
                tick();
            end
            s_ack_i = 1'b1;
            s_dat_i = 32'hB0000000 + s;
            expect_resp(0, 1'b0, 32'hB0000000 + s);
            #1;
            checks++;
            if (grant_o !== 2'b01 || m1_ack_o !== 1'b0 || m0_ack_o !== 1'b1) begin
                errors++;
                $display("FAIL burst_ack%0d: grant=%b ack0=%b ack1=%b",
                         s, grant_o, m0_ack_o, m1_ack_o);
            end
            tick();
            s_ack_i = 1'b0;
            drive(0, 1, 1, 1, 32'h504 + 4 * s, 32'h2 + s, 4'hF);
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        #1;
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL burst_drop: grant=%b, want 01", grant_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b00 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap: grant=%b ack1=%b, want 00/0", grant_o, m1_ack_o);
        end
        tick();
        checks++;
        if (grant_o !== 2'b10 || s_adr_o !== 32'h900) begin
            errors++;
            $display("FAIL burst_m1: grant=%b adr=%h, want 10/900", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'h00000E01;
        expect_resp(1, 1'b0, 32'h00000E01);
        tick();
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 1, 1, 32'h600, 32'h66, 4'h3);
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rmid_grant: grant=%b, want 01", grant_o);
        end
        tick();
        rst = 1'b1;
        s_ack_i = 1'b1;
        s_dat_i = 32'h0000F00D;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 ||
            m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_comb: cyc=%b stb=%b ack0=%b err0=%b, want 0",
                     s_cyc_o, s_stb_o, m0_ack_o, m0_err_o);
        end
        tick();
        rst = 1'b0;
        idle_all();
        #1;
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL rmid_idle: grant=%b, want 00", grant_o);
        end
        drive(0, 1, 1, 0, 32'h610, '0, 4'hF);
        drive(1, 1, 1, 0, 32'h910, '0, 4'hF);
        tick();
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rmid_last: grant=%b, want 01", grant_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 32'h00000D01;
        expect_resp(0, 1'b0, 32'h00000D01);
        tick();
        idle_all();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_ack_in_idle();
        test_single();
        test_tie();
        test_timeout();
        test_collision();
        test_burst();
        test_reset_mid();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
